pyrxaclbufctrl: RTL and testbench

Receive-side ACL payload buffer control for the baseband (Vol2 Part B ch 4.5). The link controller writes each received ACL payload into one of two 256x32 single-port SRAM banks. The baseband state machine (BSM) reads completed payloads from the other bank. The block also applies the ARQ rules: SEQN duplicate filtering, CRC-based acceptance and buffer-full NAK. It generates the ARQN bit that the TX path returns in the next header.

---
 rtl/pybb_pkg.sv | 25 ++
 rtl/sram256x32_1p.sv | 26 ++
 rtl/pyrxaclbufctrl.sv | 199 +++++++++++++++++++
 tb/tb_pyrxaclbufctrl.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/pybb_pkg.sv
// Shared baseband constants for the RX ACL payload buffer: buffer geometry,
// receive FSM states, ARQN encodings and the byte-length to word-count helper.
package pybb_pkg;

  localparam int ACL_BUF_AW = 8;
  localparam int ACL_BUF_DW = 32;
  localparam int ACL_LEN_W  = 10;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RECV    = 2'd1,
    DISCARD = 2'd2
  } rx_state_e;

  localparam logic ARQN_ACK = 1'b1;
  localparam logic ARQN_NAK = 1'b0;

  // Number of 32-bit words needed to hold len bytes: (len+3)>>2, up to 256.
  function automatic logic [8:0] len_words(input logic [ACL_LEN_W-1:0] len);
    logic [ACL_LEN_W:0] sum;
    sum = {1'b0, len} + 11'd3;
    return sum[ACL_LEN_W:2];
  endfunction

endpackage

// File: rtl/sram256x32_1p.sv
// 256x32 single-port synchronous SRAM model: write when cs&we, otherwise a
// read with the data registered on the following cycle.
module sram256x32_1p
  import pybb_pkg::*;
(
  input  logic                  clk,
  input  logic                  cs,
  input  logic                  we,
  input  logic [ACL_BUF_AW-1:0] addr,
  input  logic [ACL_BUF_DW-1:0] din,
  output logic [ACL_BUF_DW-1:0] dout
);

  logic [ACL_BUF_DW-1:0] mem_q [1 << ACL_BUF_AW];
  logic [ACL_BUF_DW-1:0] dout_q;

  always_ff @(posedge clk) begin
    if (cs) begin
      if (we) mem_q[addr] <= din;
      else    dout_q      <= mem_q[addr];
    end
  end

  assign dout = dout_q;

endmodule

// File: rtl/pyrxaclbufctrl.sv
// RX ACL ping-pong payload buffer with SEQN duplicate filter, CRC/full ARQN
// generation and BSM read port. Optional length check: RXACL_LEN_CHECK_EN.
//
// state   | meaning
// IDLE    | waiting for an accepted ACL header
// RECV    | payload words written into the fill bank
// DISCARD | payload dropped (duplicate or both banks full)
module pyrxaclbufctrl
  import pybb_pkg::*;
(
  input  logic                  clk_6M,
  input  logic                  rstz,
  input  logic                  rx_start,
  input  logic                  rx_seqn,
  input  logic [ACL_LEN_W-1:0]  rx_len,
  input  logic [ACL_BUF_AW-1:0] lnctrl_addr,
  input  logic [ACL_BUF_DW-1:0] lnctrl_din,
  input  logic                  lnctrl_we,
  input  logic                  rx_done,
  input  logic                  rx_crcok,
  input  logic [ACL_BUF_AW-1:0] bsm_addr,
  input  logic                  bsm_cs,
  input  logic                  bsm_release,
  output logic [ACL_BUF_DW-1:0] bsm_dout,
  output logic                  bsm_dout_vld,
  output logic                  rxbuf_rdy,
  output logic [ACL_LEN_W-1:0]  rxbuf_len,
  output logic                  rx_arqn,
  output logic                  rx_dup,
  output logic                  rx_len_err
);

  rx_state_e state_q, state_d;
  logic wbank_q, wbank_d, rbank_q, rbank_d;
  logic [1:0] full_q, full_d;
  logic [1:0][ACL_LEN_W-1:0] blen_q, blen_d;
  logic last_seqn_q, last_seqn_d, seqn_vld_q, seqn_vld_d;
  logic pkt_seqn_q, pkt_seqn_d;
  logic [ACL_LEN_W-1:0] pkt_len_q, pkt_len_d;
  logic arqn_q, arqn_d, dup_q, dup_d;
  logic rd_vld1_q, rd_vld1_d, rd_bank_q, rd_bank_d;
  logic [ACL_BUF_DW-1:0] dout_q, dout_d;
  logic dout_vld_q, dout_vld_d;

  logic wr_en, len_ok;
  logic [1:0] wr_side, bank_cs, bank_we;
  logic [ACL_BUF_AW-1:0] bank_addr [2];
  logic [ACL_BUF_DW-1:0] bank_dout [2];

  assign wr_en = (state_q == RECV) && lnctrl_we;

  always_comb begin
    state_d     = state_q;
    wbank_d     = wbank_q;
    rbank_d     = rbank_q;
    full_d      = full_q;
    blen_d      = blen_q;
    last_seqn_d = last_seqn_q;
    seqn_vld_d  = seqn_vld_q;
    pkt_seqn_d  = pkt_seqn_q;
    pkt_len_d   = pkt_len_q;
    arqn_d      = arqn_q;
    dup_d       = 1'b0;

    if (bsm_release && full_q[rbank_q]) begin
      full_d[rbank_q] = 1'b0;
      rbank_d         = ~rbank_q;
    end

    if (rx_start) begin
      // A header arriving mid-packet abandons the old payload like a CRC failure.
      if (state_q == RECV) arqn_d = ARQN_NAK;
      pkt_seqn_d = rx_seqn;
      pkt_len_d  = rx_len;
      if (seqn_vld_q && (rx_seqn == last_seqn_q)) begin
        state_d = DISCARD;
        dup_d   = 1'b1;
        arqn_d  = ARQN_ACK;
      end else if (full_q[wbank_q]) begin
        state_d = DISCARD;
        arqn_d  = ARQN_NAK;
      end else begin
        state_d = RECV;
      end
    end else if (rx_done) begin
      state_d = IDLE;
      if (state_q == RECV) begin
        if (rx_crcok && len_ok) begin
          full_d[wbank_q] = 1'b1;
          blen_d[wbank_q] = pkt_len_q;
          last_seqn_d     = pkt_seqn_q;
          seqn_vld_d      = 1'b1;
          wbank_d         = ~wbank_q;
          arqn_d          = ARQN_ACK;
        end else begin
          arqn_d = ARQN_NAK;
        end
      end
    end
  end

  always_comb begin
    rd_vld1_d  = bsm_cs;
    rd_bank_d  = rbank_q;
    dout_vld_d = rd_vld1_q;
    dout_d     = rd_vld1_q ? bank_dout[rd_bank_q] : dout_q;
  end

  always_ff @(posedge clk_6M) begin
    if (!rstz) begin
      state_q     <= IDLE;
      wbank_q     <= 1'b0;
      rbank_q     <= 1'b0;
      full_q      <= '0;
      blen_q      <= '0;
      last_seqn_q <= 1'b0;
      seqn_vld_q  <= 1'b0;
      pkt_seqn_q  <= 1'b0;
      pkt_len_q   <= '0;
      arqn_q      <= ARQN_NAK;
      dup_q       <= 1'b0;
      rd_vld1_q   <= 1'b0;
      rd_bank_q   <= 1'b0;
      dout_q      <= '0;
      dout_vld_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      wbank_q     <= wbank_d;
      rbank_q     <= rbank_d;
      full_q      <= full_d;
      blen_q      <= blen_d;
      last_seqn_q <= last_seqn_d;
      seqn_vld_q  <= seqn_vld_d;
      pkt_seqn_q  <= pkt_seqn_d;
      pkt_len_q   <= pkt_len_d;
      arqn_q      <= arqn_d;
      dup_q       <= dup_d;
      rd_vld1_q   <= rd_vld1_d;
      rd_bank_q   <= rd_bank_d;
      dout_q      <= dout_d;
      dout_vld_q  <= dout_vld_d;
    end
  end

`ifdef RXACL_LEN_CHECK_EN
  logic [8:0] wcnt_q, wcnt_d;
  logic len_err_q, len_err_d;

  always_comb begin
    wcnt_d = wcnt_q;
    if (rx_start)   wcnt_d = '0;
    else if (wr_en) wcnt_d = wcnt_q + 9'd1;
  end

  assign len_ok    = (wcnt_q == len_words(pkt_len_q));
  assign len_err_d = (state_q == RECV) && !rx_start && rx_done && rx_crcok && !len_ok;

  always_ff @(posedge clk_6M) begin
    if (!rstz) begin
      wcnt_q    <= '0;
      len_err_q <= 1'b0;
    end else begin
      wcnt_q    <= wcnt_d;
      len_err_q <= len_err_d;
    end
  end

  assign rx_len_err = len_err_q;
`else
  assign len_ok     = 1'b1;
  assign rx_len_err = 1'b0;
`endif

  // A bank belongs to the link controller only while it is the free fill bank;
  // with both banks full the shared bank index must stay readable by the BSM.
  for (genvar b = 0; b < 2; b++) begin : g_bank
    assign wr_side[b]   = (wbank_q == 1'(b)) && !full_q[b];
    assign bank_cs[b]   = wr_side[b] ? wr_en : bsm_cs;
    assign bank_we[b]   = wr_side[b] && wr_en;
    assign bank_addr[b] = wr_side[b] ? lnctrl_addr : bsm_addr;

    sram256x32_1p u_sram (
      .clk  (clk_6M),
      .cs   (bank_cs[b]),
      .we   (bank_we[b]),
      .addr (bank_addr[b]),
      .din  (lnctrl_din),
      .dout (bank_dout[b])
    );
  end

  assign bsm_dout     = dout_q;
  assign bsm_dout_vld = dout_vld_q;
  assign rxbuf_rdy    = full_q[rbank_q];
  assign rxbuf_len    = blen_q[rbank_q];
  assign rx_arqn      = arqn_q;
  assign rx_dup       = dup_q;

endmodule

// File: tb/tb_pyrxaclbufctrl.sv
// Bench for pyrxaclbufctrl: directed ARQ scenarios plus random traffic against
// a payload-FIFO reference model; BSM reads checked by a scoreboard monitor.
module tb_pyrxaclbufctrl;

  logic        clk_6M = 1'b0;
  logic        rstz = 1'b0;
  logic        rx_start = 1'b0, rx_seqn = 1'b0;
  logic [9:0]  rx_len = '0;
  logic [7:0]  lnctrl_addr = '0;
  logic [31:0] lnctrl_din = '0;
  logic        lnctrl_we = 1'b0, rx_done = 1'b0, rx_crcok = 1'b0;
  logic [7:0]  bsm_addr = '0;
  logic        bsm_cs = 1'b0, bsm_release = 1'b0;
  logic [31:0] bsm_dout;
  logic        bsm_dout_vld, rxbuf_rdy, rx_arqn, rx_dup, rx_len_err;
  logic [9:0]  rxbuf_len;

  pyrxaclbufctrl dut (
    .clk_6M(clk_6M), .rstz(rstz), .rx_start(rx_start), .rx_seqn(rx_seqn),
    .rx_len(rx_len), .lnctrl_addr(lnctrl_addr), .lnctrl_din(lnctrl_din),
    .lnctrl_we(lnctrl_we), .rx_done(rx_done), .rx_crcok(rx_crcok),
    .bsm_addr(bsm_addr), .bsm_cs(bsm_cs), .bsm_release(bsm_release),
    .bsm_dout(bsm_dout), .bsm_dout_vld(bsm_dout_vld), .rxbuf_rdy(rxbuf_rdy),
    .rxbuf_len(rxbuf_len), .rx_arqn(rx_arqn), .rx_dup(rx_dup),
    .rx_len_err(rx_len_err)
  );

  always #5 clk_6M = ~clk_6M;

  int unsigned cyc = 0;
  always @(posedge clk_6M) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_6M);
    #1;
  endtask

  // Reference model: FIFO of committed payloads (front = read bank), ARQ state.
  logic [31:0] words_q[$];
  int          nwq[$];
  int          lenq[$];
  bit          m_last = 1'b0, m_vld = 1'b0, m_arqn = 1'b0;

  typedef struct {
    logic [31:0] data;
    int unsigned cyc;
  } rd_t;
  rd_t rdq[$];

  initial begin : monitor
    rd_t e;
    forever begin
      @(negedge clk_6M);
      if (bsm_dout_vld) begin
        if (rdq.size() == 0) begin
          chk("unexpected_vld", 32'(bsm_dout_vld), 32'(0));
        end else begin
          e = rdq.pop_front();
          chk("rd_data", bsm_dout, e.data);
          chk("rd_latency", 32'(cyc - e.cyc), 32'(2));
        end
      end
    end
  end

  task automatic model_pop();
    for (int i = 0; i < nwq[0]; i++) void'(words_q.pop_front());
    void'(nwq.pop_front());
    void'(lenq.pop_front());
  endtask

  task automatic check_status(input string tag);
    chk({tag, "_rdy"}, 32'(rxbuf_rdy), 32'(nwq.size() > 0));
    if (nwq.size() > 0) chk({tag, "_len"}, 32'(rxbuf_len), 32'(lenq[0]));
  endtask

  task automatic send_pkt(input bit seqn, input int len, input int nw, input bit crcok, input bit rel);
    bit dup, disc, ok, lerr;
    logic [31:0] d [64];
    dup  = m_vld && (seqn == m_last);
    disc = dup || (nwq.size() == 2);
    rx_start = 1'b1; rx_seqn = seqn; rx_len = len[9:0];
    tick();
    rx_start = 1'b0;
    if (dup) m_arqn = 1'b1;
    else if (disc) m_arqn = 1'b0;
    chk("dup_pulse", 32'(rx_dup), 32'(dup));
    chk("arqn_start", 32'(rx_arqn), 32'(m_arqn));
    for (int i = 0; i < nw; i++) begin
      lnctrl_we = 1'b1; lnctrl_addr = i[7:0]; lnctrl_din = $urandom; d[i] = lnctrl_din;
      tick();
    end
    lnctrl_we = 1'b0;
    rx_done = 1'b1; rx_crcok = crcok; bsm_release = rel;
    tick();
    rx_done = 1'b0; rx_crcok = 1'b0; bsm_release = 1'b0;
    if (rel && nwq.size() > 0) model_pop();
    lerr = 1'b0;
    if (!disc) begin
      ok = crcok;
`ifdef RXACL_LEN_CHECK_EN
      if (crcok && (nw != (len + 3) / 4)) begin ok = 1'b0; lerr = 1'b1; end
`endif
      if (ok) begin
        for (int i = 0; i < nw; i++) words_q.push_back(d[i]);
        nwq.push_back(nw);
        lenq.push_back(len);
        m_last = seqn; m_vld = 1'b1; m_arqn = 1'b1;
      end else begin
        m_arqn = 1'b0;
      end
    end
    chk("arqn_done", 32'(rx_arqn), 32'(m_arqn));
    chk("len_err", 32'(rx_len_err), 32'(lerr));
    check_status("done");
  endtask

  task automatic read_front(input int n);
    int m;
    if (nwq.size() == 0) return;
    m = (n < nwq[0]) ? n : nwq[0];
    if (m == 0) return;
    for (int i = 0; i < m; i++) begin
      bsm_cs = 1'b1; bsm_addr = i[7:0];
      rdq.push_back('{words_q[i], cyc});
      tick();
    end
    bsm_cs = 1'b0;
    repeat (3) tick();
    chk("dout_hold", bsm_dout, words_q[m-1]);
  endtask

  task automatic release_bank();
    bsm_release = 1'b1;
    tick();
    bsm_release = 1'b0;
    if (nwq.size() > 0) model_pop();
    check_status("release");
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_dout"}, bsm_dout, 32'(0));
    chk({tag, "_vld"}, 32'(bsm_dout_vld), 32'(0));
    chk({tag, "_rdy"}, 32'(rxbuf_rdy), 32'(0));
    chk({tag, "_len"}, 32'(rxbuf_len), 32'(0));
    chk({tag, "_arqn"}, 32'(rx_arqn), 32'(0));
    chk({tag, "_dup"}, 32'(rx_dup), 32'(0));
    chk({tag, "_lenerr"}, 32'(rx_len_err), 32'(0));
  endtask

  initial begin : stim
    int seqn, len, nw;
    repeat (3) tick();
    check_reset_outputs("rst");
    rstz = 1'b1;
    tick();

    // Good packet, then readback
    send_pkt(1'b0, 17, 5, 1'b1, 1'b0);
    read_front(5);
    // Duplicate
    send_pkt(1'b0, 17, 5, 1'b1, 1'b0);
    // CRC fail then retry
    send_pkt(1'b1, 30, 8, 1'b0, 1'b0);
    send_pkt(1'b1, 30, 8, 1'b1, 1'b0);
    // Both banks full: NAK, no write into the readable bank
    send_pkt(1'b0, 12, 3, 1'b1, 1'b0);
    read_front(5);
    release_bank();
    send_pkt(1'b0, 12, 3, 1'b1, 1'b0);
    read_front(8);
    // Commit and release in the same cycle
    release_bank();
    send_pkt(1'b1, 40, 10, 1'b1, 1'b1);
    read_front(10);
    // Release with nothing ready is ignored
    release_bank();
    release_bank();

    // Reset in the middle of a payload
    send_pkt(1'b0, 8, 2, 1'b1, 1'b0);
    rx_start = 1'b1; rx_seqn = 1'b0; rx_len = 10'd20;
    tick();
    rx_start = 1'b0;
    repeat (2) begin
      lnctrl_we = 1'b1; lnctrl_addr = 8'd0; lnctrl_din = $urandom;
      tick();
    end
    lnctrl_we = 1'b0;
    rstz = 1'b0;
    tick(); tick();
    check_reset_outputs("midrst");
    rstz = 1'b1;
    words_q.delete(); nwq.delete(); lenq.delete();
    m_vld = 1'b0; m_last = 1'b0; m_arqn = 1'b0;
    tick();
    send_pkt(1'b0, 8, 2, 1'b1, 1'b0);
    read_front(2);

    // Word count short of the length
    send_pkt(1'b1, 17, 4, 1'b1, 1'b0);

    for (int it = 0; it < 80; it++) begin
      if ($urandom_range(0, 9) < 2) begin
        release_bank();
      end else begin
        seqn = ($urandom_range(0, 3) == 0) ? int'(m_last) : int'($urandom_range(0, 1));
        len  = int'($urandom_range(1, 200));
        nw   = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 8)) : (len + 3) / 4;
        send_pkt(seqn[0], len, nw, ($urandom_range(0, 3) != 0), ($urandom_range(0, 3) == 0));
        read_front(int'($urandom_range(1, 4)));
      end
    end

    repeat (4) tick();
    chk("rd_pending", 32'(rdq.size()), 32'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
